// File: rtl/npc_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : npc_pc_unit
// Description : Fetch PC register and next-PC selection for a MIPS-style
//               pipeline with a single branch delay slot. Consumes the
//               ID-stage branch decision, drives the IM address, produces
//               the jal/jalr link address, flags bad fetch addresses and
//               counts taken redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  pc_op,
    input  logic        br_true,
    input  logic [31:0] pc_D,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_F,
    output logic [31:0] link_D,
    output logic        redirect,
    output logic        pc_fault,
    output logic [15:0] taken_cnt
);

    // Flow-type encodings from the ID-stage decoder
    localparam logic [2:0] c_OP_SEQ = 3'b000;
    localparam logic [2:0] c_OP_BR  = 3'b001;
    localparam logic [2:0] c_OP_J   = 3'b010;
    localparam logic [2:0] c_OP_JR  = 3'b011;

    // Fetch window bounds held at 33 bits so RESET_PC + 4*IM_WORDS never wraps
    localparam logic [32:0] c_PC_LO = {1'b0, RESET_PC};
    localparam logic [32:0] c_PC_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) * 33'd4);

    logic [31:0] r_pc;
    logic        r_fault;
    logic [15:0] r_taken_cnt;

    logic [31:0] w_pc_d_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_next;
    logic        w_redirect;
    logic        w_fault;

    assign w_pc_d_plus4 = pc_D + 32'd4;
    assign w_br_off     = {{14{imm16[15]}}, imm16, 2'b00};
    assign w_br_tgt     = w_pc_d_plus4 + w_br_off;
    assign w_j_tgt      = {w_pc_d_plus4[31:28], instr_index, 2'b00};

    // Next-PC mux; unknown pc_op codes fall through to sequential flow
    always_comb begin
        w_next     = r_pc + 32'd4;
        w_redirect = 1'b0;
        case (pc_op)
            c_OP_BR: begin
                if (br_true) begin
                    w_next     = w_br_tgt;
                    w_redirect = 1'b1;
                end
            end
            c_OP_J: begin
                w_next     = w_j_tgt;
                w_redirect = 1'b1;
            end
            c_OP_JR: begin
                w_next     = jr_target;
                w_redirect = 1'b1;
            end
            c_OP_SEQ: begin
                w_next     = r_pc + 32'd4;
                w_redirect = 1'b0;
            end
            default: begin
                w_next     = r_pc + 32'd4;
                w_redirect = 1'b0;
            end
        endcase
    end

    // Misaligned or out-of-window fetch address, compared at full width
    assign w_fault = (w_next[1:0] != 2'b00)
                   || ({1'b0, w_next} <  c_PC_LO)
                   || ({1'b0, w_next} >= c_PC_HI);

    // PC, sticky fault and redirect counter; reset wins over stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_fault     <= 1'b0;
            r_taken_cnt <= 16'd0;
        end else if (!stall) begin
            r_pc <= w_next;
            if (w_redirect) begin
                r_taken_cnt <= r_taken_cnt + 16'd1;
            end
            if (w_fault) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign pc_F      = r_pc;
    assign link_D    = pc_D + 32'd8;
    assign redirect  = w_redirect;
    assign pc_fault  = r_fault;
    assign taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_npc_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_pc_unit
// Description : Directed self-checking bench for npc_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_op;
    logic        br_true;
    logic [31:0] pc_D;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] pc_F;
    logic [31:0] link_D;
    logic        redirect;
    logic        pc_fault;
    logic [15:0] taken_cnt;

    int n_checks;
    int n_errors;

    npc_pc_unit #(
        .RESET_PC (32'h0000_3000),
        .IM_WORDS (1024)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .pc_op       (pc_op),
        .br_true     (br_true),
        .pc_D        (pc_D),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .pc_F        (pc_F),
        .link_D      (link_D),
        .redirect    (redirect),
        .pc_fault    (pc_fault),
        .taken_cnt   (taken_cnt)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        pc_op       = 3'b000;
        br_true     = 1'b0;
        pc_D        = 32'h0;
        imm16       = 16'h0;
        instr_index = 26'h0;
        jr_target   = 32'h0;
        tick();
        reset = 1'b0;

        // Reset state and sequential flow
        check("rst_pc",    pc_F,      32'h3000);
        check("rst_fault", {31'd0, pc_fault}, 32'd0);
        check("rst_cnt",   {16'd0, taken_cnt}, 32'd0);
        check("seq_redir", {31'd0, redirect}, 32'd0);
        tick(); check("seq1", pc_F, 32'h3004);
        tick(); check("seq2", pc_F, 32'h3008);
        tick(); check("seq3", pc_F, 32'h300C);
        check("seq_cnt", {16'd0, taken_cnt}, 32'd0);

        // Backward conditional branch taken: 3014 - 16 = 3004
        pc_D = 32'h3010; pc_op = 3'b001; imm16 = 16'hFFFC; br_true = 1'b1;
        #1;
        check("br_redir", {31'd0, redirect}, 32'd1);
        tick();
        check("br_pc",  pc_F, 32'h3004);
        check("br_cnt", {16'd0, taken_cnt}, 32'd1);

        // Same branch not taken: sequential
        br_true = 1'b0;
        #1;
        check("brnt_redir", {31'd0, redirect}, 32'd0);
        tick();
        check("brnt_pc",  pc_F, 32'h3008);
        check("brnt_cnt", {16'd0, taken_cnt}, 32'd1);

        // Undefined pc_op treated as sequential even with br_true set
        pc_op = 3'b101; br_true = 1'b1;
        #1;
        check("op5_redir", {31'd0, redirect}, 32'd0);
        tick();
        check("op5_pc", pc_F, 32'h300C);

        // j/jal: {3024[31:28], C10, 00} = 3040, link = 3028
        pc_D = 32'h3020; pc_op = 3'b010; instr_index = 26'h0000C10; br_true = 1'b0;
        #1;
        check("j_link",  link_D, 32'h3028);
        check("j_redir", {31'd0, redirect}, 32'd1);
        tick();
        check("j_pc",  pc_F, 32'h3040);
        check("j_cnt", {16'd0, taken_cnt}, 32'd2);

        // Stall with a pending forward branch: 3024 + 16 = 3034
        pc_op = 3'b001; br_true = 1'b1; imm16 = 16'h0004; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_pc",    pc_F, 32'h3040);
            check("stl_cnt",   {16'd0, taken_cnt}, 32'd2);
            check("stl_redir", {31'd0, redirect}, 32'd1);
        end
        stall = 1'b0;
        tick();
        check("unstl_pc",  pc_F, 32'h3034);
        check("unstl_cnt", {16'd0, taken_cnt}, 32'd3);
        pc_op = 3'b000; br_true = 1'b0;
        tick();
        check("post_stl_pc",  pc_F, 32'h3038);
        check("post_stl_cnt", {16'd0, taken_cnt}, 32'd3);

        // jr to misaligned address: loads it and sets sticky fault
        pc_op = 3'b011; jr_target = 32'h3002;
        tick();
        check("jr_mis_pc",    pc_F, 32'h3002);
        check("jr_mis_fault", {31'd0, pc_fault}, 32'd1);
        check("jr_mis_cnt",   {16'd0, taken_cnt}, 32'd4);
        pc_op = 3'b010; pc_D = 32'h3020; instr_index = 26'h0000C10;
        tick();
        check("sticky_pc",    pc_F, 32'h3040);
        check("sticky_fault", {31'd0, pc_fault}, 32'd1);
        pc_op = 3'b000;
        tick();
        check("sticky_fault2", {31'd0, pc_fault}, 32'd1);

        // Reset dominates stall and a pending jump
        reset = 1'b1; stall = 1'b1; pc_op = 3'b010;
        tick();
        check("rst2_pc",    pc_F, 32'h3000);
        check("rst2_cnt",   {16'd0, taken_cnt}, 32'd0);
        check("rst2_fault", {31'd0, pc_fault}, 32'd0);
        reset = 1'b0; stall = 1'b0;

        // Below the fetch window
        pc_op = 3'b011; jr_target = 32'h2FFC;
        tick();
        check("lo_pc",    pc_F, 32'h2FFC);
        check("lo_fault", {31'd0, pc_fault}, 32'd1);

        // Last valid word, then first word past the window
        reset = 1'b1; tick(); reset = 1'b0;
        jr_target = 32'h3FFC;
        tick();
        check("hi_ok_pc",    pc_F, 32'h3FFC);
        check("hi_ok_fault", {31'd0, pc_fault}, 32'd0);
        jr_target = 32'h4000;
        tick();
        check("hi_bad_fault", {31'd0, pc_fault}, 32'd1);

        // Counter wrap after 0xFFFF redirects
        reset = 1'b1; tick(); reset = 1'b0;
        pc_op = 3'b010; pc_D = 32'h3020; instr_index = 26'h0000C10;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check("cnt_full", {16'd0, taken_cnt}, 32'h0000FFFF);
        tick();
        check("cnt_wrap", {16'd0, taken_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
